// File: rtl/dvi_pkg.sv
// Shared definitions for the CH7301 12-bit DDR DVI link: lock-state enum,
// counter width, and the bit mapping of RGB onto the two half-words. The
// transmit side uses the same mapping constants.
package dvi_pkg;

  localparam int DVI_CW = 12;  // coordinate / geometry counter width
  localparam int DVI_DW = 12;  // width of one DDR half-word

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    TRACKING = 2'd1,
    LOCKED   = 2'd2
  } dvi_lock_e;

  // Bit slices of the rising (lo) and falling (hi) half-words
  localparam int DVI_BLUE_LO_MSB  = 7;
  localparam int DVI_BLUE_LO_LSB  = 0;
  localparam int DVI_GREEN_LO_MSB = 11;
  localparam int DVI_GREEN_LO_LSB = 8;
  localparam int DVI_GREEN_HI_MSB = 3;
  localparam int DVI_GREEN_HI_LSB = 0;
  localparam int DVI_RED_HI_MSB   = 11;
  localparam int DVI_RED_HI_LSB   = 4;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } dvi_rgb_t;

  // Inverse of the transmit mapping: rebuild one 24-bit pixel
  function automatic dvi_rgb_t dvi_decode(input logic [DVI_DW-1:0] lo,
                                          input logic [DVI_DW-1:0] hi);
    dvi_rgb_t p;
    p.blue  = lo[DVI_BLUE_LO_MSB:DVI_BLUE_LO_LSB];
    p.green = {hi[DVI_GREEN_HI_MSB:DVI_GREEN_HI_LSB],
               lo[DVI_GREEN_LO_MSB:DVI_GREEN_LO_LSB]};
    p.red   = hi[DVI_RED_HI_MSB:DVI_RED_HI_LSB];
    return p;
  endfunction

endpackage

// File: rtl/dvi_in_capture_if.sv
// DVI receive bus as delivered by the board-level IDDR capture flops.
// master = the capture side driving the bus, slave = dvi_in_capture.
interface dvi_in_capture_if;
  import dvi_pkg::*;

  logic [DVI_DW-1:0] dvi_d_lo;
  logic [DVI_DW-1:0] dvi_d_hi;
  logic              dvi_h;
  logic              dvi_v;
  logic              dvi_de;

  modport master (output dvi_d_lo, dvi_d_hi, dvi_h, dvi_v, dvi_de);
  modport slave  (input  dvi_d_lo, dvi_d_hi, dvi_h, dvi_v, dvi_de);
endinterface

// File: rtl/dvi_geom_meter.sv
// Active-geometry meter for the DVI receiver. Works on stage-1 (registered,
// polarity-normalised) de/hs/vs. Holds the pixel and line counters, the
// per-frame line-length comparison, the matching-frame counter and the lock
// FSM. Optional macro DVI_IN_HSYNC_CHECK_EN adds a check for exactly one hs
// rising edge per line.
module dvi_geom_meter
  import dvi_pkg::*;
#(
  parameter int LOCK_FRAMES = 2
) (
  input  logic              clk_pix,
  input  logic              rst_n,
  input  logic              de,
  input  logic              hs,
  input  logic              vs,
  output logic [DVI_CW-1:0] xc,
  output logic              line_end,
  output logic              frame_end,
  output logic [DVI_CW-1:0] h_meas,
  output logic [DVI_CW-1:0] v_meas,
  output logic              lock_ok
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

  function automatic logic [DVI_CW-1:0] sat_inc(input logic [DVI_CW-1:0] v);
    return (v == '1) ? v : v + DVI_CW'(1);
  endfunction

  logic              de_d, vs_d;
  logic              armed;      // a vs edge has been seen since reset
  logic              frame_bad;
  logic [DVI_CW-1:0] lc, ref_len;
  logic [3:0]        match_cnt;
  dvi_lock_e         state, state_n;

  // Values as they stand once the current cycle's line end is folded in
  logic [DVI_CW-1:0] lc_f, ref_f;
  logic              bad_f, good, same, hs_bad;
  logic [3:0]        match_f;

  assign line_end  = de_d & ~de;
  assign frame_end = vs & ~vs_d;
  assign lock_ok   = (match_cnt >= LOCK_N);

`ifdef DVI_IN_HSYNC_CHECK_EN
  logic       hs_d, hs_rise;
  logic [1:0] hs_cnt;

  assign hs_rise = hs & ~hs_d;
  // The first line of a frame is skipped: its interval spans vertical blanking
  assign hs_bad  = line_end && armed && (lc != '0) && (hs_cnt != 2'd1);

  // Count hs rising edges between successive de falling edges
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      hs_d   <= 1'b0;
      hs_cnt <= 2'd0;
    end else begin
      hs_d <= hs;
      if (line_end)
        hs_cnt <= {1'b0, hs_rise};
      else if (hs_rise && hs_cnt != 2'd3)
        hs_cnt <= hs_cnt + 2'd1;
    end
  end
`else
  logic unused_hs;
  assign unused_hs = hs;
  assign hs_bad    = 1'b0;
`endif

  // Fold a line end into the frame tally and judge the frame
  always_comb begin
    lc_f  = lc;
    ref_f = ref_len;
    bad_f = frame_bad | hs_bad;
    if (line_end && armed) begin
      lc_f = sat_inc(lc);
      if (lc == '0)
        ref_f = xc;
      else if (xc != ref_len)
        bad_f = 1'b1;
    end
    good    = armed && !bad_f && (lc_f != '0) && (ref_f != '0);
    same    = (ref_f == h_meas) && (lc_f == v_meas);
    match_f = 4'd0;
    if (good) begin
      if (!same)
        match_f = 4'd1;
      else if (match_cnt >= LOCK_N)
        match_f = LOCK_N;
      else
        match_f = match_cnt + 4'd1;
    end
  end

  // Counters, reference length and per-frame geometry capture
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      de_d      <= 1'b0;
      vs_d      <= 1'b0;
      armed     <= 1'b0;
      xc        <= '0;
      lc        <= '0;
      ref_len   <= '0;
      frame_bad <= 1'b0;
      match_cnt <= 4'd0;
      h_meas    <= '0;
      v_meas    <= '0;
    end else begin
      de_d <= de;
      vs_d <= vs;
      xc   <= de ? sat_inc(xc) : '0;
      if (frame_end) begin
        armed     <= 1'b1;
        lc        <= '0;
        ref_len   <= '0;
        frame_bad <= 1'b0;
        match_cnt <= match_f;
        if (good) begin
          h_meas <= ref_f;
          v_meas <= lc_f;
        end
      end else begin
        lc        <= lc_f;
        ref_len   <= ref_f;
        frame_bad <= bad_f;
      end
    end
  end

  // Lock FSM state register
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) state <= UNLOCKED;
    else        state <= state_n;
  end

  // Lock FSM next state, evaluated only at frame boundaries
  always_comb begin
    state_n = state;
    if (frame_end) begin
      case (state)
        UNLOCKED: begin
          if (good) state_n = (match_f >= LOCK_N) ? LOCKED : TRACKING;
        end
        TRACKING: begin
          if (!good)                 state_n = UNLOCKED;
          else if (match_f >= LOCK_N) state_n = LOCKED;
        end
        LOCKED: begin
          if (!good)                 state_n = UNLOCKED;
          else if (match_f < LOCK_N)  state_n = TRACKING;
        end
        default: state_n = UNLOCKED;
      endcase
    end
  end

endmodule

// File: rtl/dvi_in_capture.sv
// Pixel-domain receiver for the CH7301 12-bit DDR DVI bus. Registers the
// captured half-words, decodes 24-bit RGB, generates x/y/sof and reports the
// measured active geometry and lock. Optional macro DVI_IN_HSYNC_CHECK_EN
// (handled in dvi_geom_meter) makes hs edges part of frame validity.
module dvi_in_capture
  import dvi_pkg::*;
#(
  parameter int LOCK_FRAMES = 2,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0
) (
  input  logic              clk_pix,
  input  logic              rst_n,
  dvi_in_capture_if.slave   dvi,
  output logic              pix_valid,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  output logic [DVI_CW-1:0] x,
  output logic [DVI_CW-1:0] y,
  output logic              sof,
  output logic [DVI_CW-1:0] h_active,
  output logic [DVI_CW-1:0] v_active,
  output logic              locked
);

  function automatic logic [DVI_CW-1:0] sat_inc(input logic [DVI_CW-1:0] v);
    return (v == '1) ? v : v + DVI_CW'(1);
  endfunction

  logic [DVI_DW-1:0] d_lo_p1, d_hi_p1;
  logic              vld_p1, hs_p1, vs_p1;

  dvi_rgb_t          rgb_p2;
  logic              vld_p2, sof_p2;
  logic [DVI_CW-1:0] x_p2, y_p2;

  logic [DVI_CW-1:0] yc;
  logic              sof_pend;

  logic [DVI_CW-1:0] xc, h_meas, v_meas;
  logic              line_end, frame_end, lock_ok;

  // Stage 1: register the bus, syncs normalised to active-high
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      d_lo_p1 <= '0;
      d_hi_p1 <= '0;
      vld_p1  <= 1'b0;
      hs_p1   <= 1'b0;
      vs_p1   <= 1'b0;
    end else begin
      d_lo_p1 <= dvi.dvi_d_lo;
      d_hi_p1 <= dvi.dvi_d_hi;
      vld_p1  <= dvi.dvi_de;
      hs_p1   <= (dvi.dvi_h == HS_POL);
      vs_p1   <= (dvi.dvi_v == VS_POL);
    end
  end

  dvi_geom_meter #(
    .LOCK_FRAMES (LOCK_FRAMES)
  ) u_meter (
    .clk_pix   (clk_pix),
    .rst_n     (rst_n),
    .de        (vld_p1),
    .hs        (hs_p1),
    .vs        (vs_p1),
    .xc        (xc),
    .line_end  (line_end),
    .frame_end (frame_end),
    .h_meas    (h_meas),
    .v_meas    (v_meas),
    .lock_ok   (lock_ok)
  );

  // Line index within the frame and pending start-of-frame marker
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      yc       <= '0;
      sof_pend <= 1'b0;
    end else if (frame_end) begin
      yc       <= '0;
      sof_pend <= 1'b1;
    end else begin
      if (line_end) yc       <= sat_inc(yc);
      if (vld_p1)   sof_pend <= 1'b0;
    end
  end

  // Stage 2: decode and attach coordinates
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      rgb_p2 <= '0;
      vld_p2 <= 1'b0;
      sof_p2 <= 1'b0;
      x_p2   <= '0;
      y_p2   <= '0;
    end else begin
      rgb_p2 <= dvi_decode(d_lo_p1, d_hi_p1);
      vld_p2 <= vld_p1;
      sof_p2 <= vld_p1 & sof_pend;
      x_p2   <= xc;
      y_p2   <= yc;
    end
  end

  // Output stage: pixel outputs plus registered geometry and lock
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid <= 1'b0;
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      x         <= '0;
      y         <= '0;
      sof       <= 1'b0;
      h_active  <= '0;
      v_active  <= '0;
      locked    <= 1'b0;
    end else begin
      pix_valid <= vld_p2;
      red       <= rgb_p2.red;
      green     <= rgb_p2.green;
      blue      <= rgb_p2.blue;
      x         <= x_p2;
      y         <= y_p2;
      sof       <= sof_p2;
      h_active  <= h_meas;
      v_active  <= v_meas;
      locked    <= lock_ok;
    end
  end

endmodule
